// File: rtl/wb_port_arbiter_if.sv
// Write-back port bundle between the pipeline/MDU producers and the register-file write-port arbiter.
// The arbiter attaches to the slave modport; the producers and the register file side use master.
interface wb_port_arbiter_if #(
    parameter int XLEN = 64
);
    logic            pipe_wen_i;
    logic [4:0]      pipe_waddr_i;
    logic [XLEN-1:0] pipe_wdata_i;
    logic            mdu_valid_i;
    logic            mdu_ready_o;
    logic [4:0]      mdu_waddr_i;
    logic [XLEN-1:0] mdu_wdata_i;
    logic            stall_o;
    logic            busy_o;
    logic [4:0]      buf_waddr_o;
    logic            rf_we_o;
    logic [4:0]      rf_waddr_o;
    logic [XLEN-1:0] rf_wdata_o;

    modport slave (
        input  pipe_wen_i, pipe_waddr_i, pipe_wdata_i,
        input  mdu_valid_i, mdu_waddr_i, mdu_wdata_i,
        output mdu_ready_o, stall_o, busy_o, buf_waddr_o,
        output rf_we_o, rf_waddr_o, rf_wdata_o
    );

    modport master (
        output pipe_wen_i, pipe_waddr_i, pipe_wdata_i,
        output mdu_valid_i, mdu_waddr_i, mdu_wdata_i,
        input  mdu_ready_o, stall_o, busy_o, buf_waddr_o,
        input  rf_we_o, rf_waddr_o, rf_wdata_o
    );
endinterface

// File: rtl/wb_port_arbiter.sv
// Register-file write-port arbiter: pipeline has priority, MDU results are buffered and force-drained on starvation.
// Optional macro WB_ARB_PERF_EN adds perf_conflict_o, a saturating count of HOLD/DRAIN cycles.
//
// state | meaning
// IDLE  | no MDU result pending; MDU accepted, written directly when the pipe is quiet
// HOLD  | one MDU result buffered, waiting for a free write-port cycle
// DRAIN | buffered result starved; pipeline stalled for one cycle to write it
module wb_port_arbiter #(
    parameter int XLEN         = 64,
    parameter int STARVE_LIMIT = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    wb_port_arbiter_if.slave   bus
`ifdef WB_ARB_PERF_EN
    ,
    output logic [31:0]        perf_conflict_o
`endif
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        HOLD  = 2'd1,
        DRAIN = 2'd2
    } state_t;

    localparam logic [3:0] WAIT_LAST = 4'(STARVE_LIMIT - 1);

    state_t          state;
    logic [3:0]      wait_cnt;
    logic [4:0]      buf_waddr;
    logic [XLEN-1:0] buf_wdata;
    logic            rf_we;
    logic [4:0]      rf_waddr;
    logic [XLEN-1:0] rf_wdata;

    logic pipe_req;
    logic mdu_fire;

    assign bus.stall_o     = (state == DRAIN);
    assign bus.busy_o      = (state != IDLE);
    assign bus.mdu_ready_o = (state == IDLE);
    assign bus.buf_waddr_o = (state != IDLE) ? buf_waddr : 5'd0;
    assign bus.rf_we_o     = rf_we;
    assign bus.rf_waddr_o  = rf_waddr;
    assign bus.rf_wdata_o  = rf_wdata;

    assign pipe_req = bus.pipe_wen_i & ~bus.stall_o;
    assign mdu_fire = bus.mdu_valid_i & bus.mdu_ready_o;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            wait_cnt  <= 4'd0;
            buf_waddr <= 5'd0;
            buf_wdata <= '0;
            rf_we     <= 1'b0;
            rf_waddr  <= 5'd0;
            rf_wdata  <= '0;
        end else begin
            rf_we <= 1'b0;
            case (state)
                IDLE: begin
                    if (pipe_req) begin
                        rf_we    <= (bus.pipe_waddr_i != 5'd0);
                        rf_waddr <= bus.pipe_waddr_i;
                        rf_wdata <= bus.pipe_wdata_i;
                        // Same-address MDU result is superseded; x0 results are never kept.
                        if (mdu_fire && bus.mdu_waddr_i != 5'd0 &&
                            bus.mdu_waddr_i != bus.pipe_waddr_i) begin
                            buf_waddr <= bus.mdu_waddr_i;
                            buf_wdata <= bus.mdu_wdata_i;
                            wait_cnt  <= 4'd0;
                            state     <= HOLD;
                        end
                    end else if (mdu_fire) begin
                        rf_we    <= (bus.mdu_waddr_i != 5'd0);
                        rf_waddr <= bus.mdu_waddr_i;
                        rf_wdata <= bus.mdu_wdata_i;
                    end
                end
                HOLD: begin
                    if (!pipe_req) begin
                        rf_we    <= 1'b1;
                        rf_waddr <= buf_waddr;
                        rf_wdata <= buf_wdata;
                        wait_cnt <= 4'd0;
                        state    <= IDLE;
                    end else begin
                        rf_we    <= (bus.pipe_waddr_i != 5'd0);
                        rf_waddr <= bus.pipe_waddr_i;
                        rf_wdata <= bus.pipe_wdata_i;
                        if (bus.pipe_waddr_i == buf_waddr) begin
                            wait_cnt <= 4'd0;
                            state    <= IDLE;
                        end else if (wait_cnt == WAIT_LAST) begin
                            state <= DRAIN;
                        end else begin
                            wait_cnt <= wait_cnt + 4'd1;
                        end
                    end
                end
                DRAIN: begin
                    rf_we    <= 1'b1;
                    rf_waddr <= buf_waddr;
                    rf_wdata <= buf_wdata;
                    wait_cnt <= 4'd0;
                    state    <= IDLE;
                end
                default: begin
                    wait_cnt <= 4'd0;
                    state    <= IDLE;
                end
            endcase
        end
    end

`ifdef WB_ARB_PERF_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_conflict_o <= 32'd0;
        end else if (state != IDLE && perf_conflict_o != 32'hFFFF_FFFF) begin
            perf_conflict_o <= perf_conflict_o + 32'd1;
        end
    end
`endif

endmodule
